// File: rtl/color_ctrl_pkg.sv
// color_ctrl_pkg: shared encodings and constants for the color frame sequencer (CHECKSUM_EN adds the checksum state)
package color_ctrl_pkg;
  localparam logic [7:0] HEADER_DEF = 8'hAA;
  localparam int FRAME_LEN_PLAIN = 4;
  localparam int FRAME_LEN_CK = 5;
`ifdef CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CK;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_R  = 3'd1,
    GET_G  = 3'd2,
    GET_B  = 3'd3,
    GET_CK = 3'd4,
    APPLY  = 3'd5
  } state_t;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_R = 3'd1,
    GET_G = 3'd2,
    GET_B = 3'd3,
    APPLY = 3'd5
  } state_t;
`endif
  function automatic logic [7:0] frame_ck(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return r ^ g ^ b;
  endfunction
endpackage

// File: rtl/gap_timer.sv
// gap_timer: saturating inter-byte gap counter flagging the last cycle before timeout
module gap_timer #(
  parameter int TW          = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TW-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise count up and hold at the timeout value
  always_comb begin
    cnt_d = clr ? '0 : (en && cnt_q != TW'(TIMEOUT_CYC)) ? cnt_q + 1'b1 : cnt_q;
  end
  // counter register, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired = cnt_q == TW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/color_frame_ctrl.sv
// color_frame_ctrl: parses [HEADER,R,G,B,(CK)] frames and commits RGB duties atomically (CHECKSUM_EN enables CK byte)
module color_frame_ctrl
  import color_ctrl_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TW          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] red_duty,
  output logic [7:0] green_duty,
  output logic [7:0] blue_duty,
  output logic       update,
  output logic       frame_err,
  output logic       busy
);
  state_t     state_q, state_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       update_q, update_d, err_q, err_d;
  logic       expired, in_frame, hdr, timeout;

  assign in_frame = state_q != IDLE && state_q != APPLY;
  assign hdr      = rx_valid && rx_data == HEADER;
  assign timeout  = in_frame && expired && !rx_valid;

  gap_timer #(.TW(TW), .TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (rx_valid || !in_frame),
    .en     (in_frame),
    .expired(expired)
  );

  // next-state, shadow capture, commit and pulse generation; a gap timeout overrides everything
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE:  state_d = hdr ? GET_R : IDLE;
      GET_R: if (rx_valid) begin
        r_d     = rx_data;
        state_d = GET_G;
      end
      GET_G: if (rx_valid) begin
        g_d     = rx_data;
        state_d = GET_B;
      end
      GET_B: if (rx_valid) begin
        b_d     = rx_data;
`ifdef CHECKSUM_EN
        state_d = GET_CK;
`else
        state_d = APPLY;
`endif
      end
`ifdef CHECKSUM_EN
      GET_CK: if (rx_valid) begin
        state_d = rx_data == frame_ck(r_q, g_q, b_q) ? APPLY : IDLE;
        err_d   = rx_data != frame_ck(r_q, g_q, b_q);
      end
`endif
      APPLY: begin
        red_d    = r_q;
        green_d  = g_q;
        blue_d   = b_q;
        update_d = 1'b1;
        state_d  = hdr ? GET_R : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
    end
  end

  // state, shadow, duty and pulse registers; reset drops any partial frame and zeroes duties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign red_duty   = red_q;
  assign green_duty = green_q;
  assign blue_duty  = blue_q;
  assign update     = update_q;
  assign frame_err  = err_q;
  assign busy       = state_q != IDLE;
endmodule
